// File: rtl/booth_mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter_pkg
// Shared definitions for the two-requester multiplier front end:
//   - state_t          : controller FSM state encoding
//   - TIMEOUT_DEFAULT  : default watchdog length (cycles spent in WAIT_RDY)
//   - grant_onehot()   : converts a requester index into its ack bit pattern
// ---------------------------------------------------------------------------
package booth_mul_arbiter_pkg;

    localparam int TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE,
        LD_AH,
        LD_XH,
        LD_AL,
        LD_XL,
        START,
        WAIT_RDY,
        DONE
    } state_t;

    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter_rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the current
// request vector; the last-granted register only moves when the owning job
// completes, so a job aborted by reset never shifts the fairness pointer.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req[1:0]     : request levels
//   update       : record 'winner' as the most recently served requester
//   winner       : index of the requester whose job just completed
//   grant_valid  : at least one request pending
//   grant_idx    : index of the requester that wins now
// ---------------------------------------------------------------------------
module booth_mul_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       winner,
    output logic       grant_valid,
    output logic       grant_idx
);

    logic last_grant;

    // Reset value 1 makes requester 0 the winner of the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (update) begin
            last_grant <= winner;
        end
    end

    // On a tie, the requester not served last time wins.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_grant;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter
// Arbitrates two requesters onto one byte-loaded multiplier. The winner's
// operands are latched at grant, streamed as A[15:8], X[15:8], A[7:0],
// X[7:0], the multiplier is started, and the controller waits for a rising
// edge on mul_ready (or a watchdog expiry) before acknowledging.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req[1:0]              : request levels, held until ack
//   a0, x0, a1, x1        : signed 16-bit operands per requester
//   ack[1:0]              : one-cycle completion pulse to the served requester
//   err                   : with ack, 1 = watchdog expired, product invalid
//   product               : signed 32-bit result, held until the next ack
//   mul_data              : operand byte bus to the multiplier
//   mul_get_a, mul_get_x  : operand byte strobes
//   mul_begin             : multiplier start strobe
//   mul_ready             : multiplier ready level
//   mul_product           : multiplier result
// ---------------------------------------------------------------------------
module booth_mul_arbiter
    import booth_mul_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic signed [15:0] a0,
    input  logic signed [15:0] x0,
    input  logic signed [15:0] a1,
    input  logic signed [15:0] x1,
    output logic [1:0]         ack,
    output logic               err,
    output logic signed [31:0] product,
    output logic [7:0]         mul_data,
    output logic               mul_get_a,
    output logic               mul_get_x,
    output logic               mul_begin,
    input  logic               mul_ready,
    input  logic signed [31:0] mul_product
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t             state;
    state_t             state_next;
    logic               owner;
    logic signed [15:0] a_reg;
    logic signed [15:0] x_reg;
    logic [CW-1:0]      wd_cnt;
    logic               rdy_prev;
    logic               err_reg;
    logic               grant_valid;
    logic               grant_idx;
    logic               rdy_rise;
    logic               wd_expired;

    booth_mul_arbiter_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .update      (state == DONE),
        .winner      (owner),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // rdy_prev follows mul_ready every cycle, including through START, so a
    // ready level left high by the previous job is not taken as completion.
    assign rdy_rise   = mul_ready & ~rdy_prev;
    assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mul_data   = 8'h00;
        mul_get_a  = 1'b0;
        mul_get_x  = 1'b0;
        mul_begin  = 1'b0;
        ack        = 2'b00;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = LD_AH;
                end
            end
            LD_AH: begin
                mul_get_a  = 1'b1;
                mul_data   = a_reg[15:8];
                state_next = LD_XH;
            end
            LD_XH: begin
                mul_get_x  = 1'b1;
                mul_data   = x_reg[15:8];
                state_next = LD_AL;
            end
            LD_AL: begin
                mul_get_a  = 1'b1;
                mul_data   = a_reg[7:0];
                state_next = LD_XL;
            end
            LD_XL: begin
                mul_get_x  = 1'b1;
                mul_data   = x_reg[7:0];
                state_next = START;
            end
            START: begin
                mul_begin  = 1'b1;
                state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (rdy_rise || wd_expired) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ack        = grant_onehot(owner);
                err        = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, watchdog and result registers. A ready edge in the
    // same cycle as watchdog expiry counts as a good completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= 1'b0;
            a_reg    <= '0;
            x_reg    <= '0;
            wd_cnt   <= '0;
            rdy_prev <= 1'b0;
            err_reg  <= 1'b0;
            product  <= '0;
        end else begin
            rdy_prev <= mul_ready;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner <= grant_idx;
                        a_reg <= grant_idx ? a1 : a0;
                        x_reg <= grant_idx ? x1 : x0;
                    end
                end
                START: begin
                    wd_cnt  <= '0;
                    err_reg <= 1'b0;
                end
                WAIT_RDY: begin
                    if (rdy_rise) begin
                        product <= mul_product;
                        err_reg <= 1'b0;
                    end else if (wd_expired) begin
                        err_reg <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_arbiter
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized phase. A behavioural multiplier rebuilds operands from the byte
// bus; expected results come straight from the requester operands.
// ---------------------------------------------------------------------------
module tb_booth_mul_arbiter;

    localparam int TIMEOUT = 64;
    localparam int BUDGET  = 200;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req;
    logic signed [15:0] a0, x0, a1, x1;
    logic [1:0]         ack;
    logic               err;
    logic signed [31:0] product;
    logic [7:0]         mul_data;
    logic               mul_get_a, mul_get_x, mul_begin;
    logic               mul_ready   = 1'b0;
    logic signed [31:0] mul_product = '0;

    int tests_run = 0;
    int failures  = 0;
    int onehot_violations = 0;
    int ack_pulses = 0;
    logic ref_last;
    logic [9:0] bus_log[$];

    int   mdl_lat = 4;
    bit   mdl_stale = 0;
    int   mdl_stale_hold = 1;
    bit   mdl_never = 0;
    logic [15:0] mdl_a = '0, mdl_x = '0;
    int   mdl_result = 0;
    int   mdl_count = 0;
    bit   mdl_busy = 0;

    typedef struct {
        logic [1:0]         req;
        logic signed [15:0] a;
        logic signed [15:0] x;
        int                 lat;
        logic [1:0]         exp_ack;
        logic signed [31:0] exp_prod;
    } vec_t;

    vec_t vecs[6];

    booth_mul_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .a0          (a0),
        .x0          (x0),
        .a1          (a1),
        .x1          (x1),
        .ack         (ack),
        .err         (err),
        .product     (product),
        .mul_data    (mul_data),
        .mul_get_a   (mul_get_a),
        .mul_get_x   (mul_get_x),
        .mul_begin   (mul_begin),
        .mul_ready   (mul_ready),
        .mul_product (mul_product)
    );

    always #5 clk = ~clk;

    // Multiplier model: assembles operands MSB byte first, drops ready on
    // begin (or later in stale mode) and raises it mdl_lat cycles later.
    always @(negedge clk) begin
        if (mul_get_a) mdl_a = {mdl_a[7:0], mul_data};
        if (mul_get_x) mdl_x = {mdl_x[7:0], mul_data};
        if (mul_begin) begin
            mdl_result = int'($signed(mdl_a)) * int'($signed(mdl_x));
            mdl_count  = 0;
            mdl_busy   = !mdl_never;
            if (!mdl_stale) mul_ready = 1'b0;
        end else if (mdl_busy) begin
            mdl_count++;
            if (mdl_stale && mdl_count == mdl_stale_hold) mul_ready = 1'b0;
            if (mdl_count == mdl_lat) begin
                mul_ready   = 1'b1;
                mul_product = mdl_result;
                mdl_busy    = 0;
            end
        end
    end

    // Bus and strobe monitor.
    always @(negedge clk) begin
        if ($countones({mul_get_a, mul_get_x, mul_begin, ack[1], ack[0]}) > 1)
            onehot_violations++;
        if (ack != 2'b00) ack_pulses++;
        if (mul_get_a || mul_get_x) bus_log.push_back({mul_get_a, mul_get_x, mul_data});
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [1:0] r, input logic signed [15:0] ia0,
                                  input logic signed [15:0] ix0, input logic signed [15:0] ia1,
                                  input logic signed [15:0] ix1);
        req = r;
        a0  = ia0;
        x0  = ix0;
        a1  = ia1;
        x1  = ix1;
    endtask

    // Drives a request at the current negedge (an IDLE cycle) and waits for
    // ack. cycles counts from the request cycle to the ack cycle inclusive.
    // At ack, the 'drop' requesters release req; the next cycle must show no ack.
    task automatic run_job(input logic [1:0] r, input logic signed [15:0] ia0,
                           input logic signed [15:0] ix0, input logic signed [15:0] ia1,
                           input logic signed [15:0] ix1, input logic [1:0] drop,
                           input bit scramble, output logic [1:0] got_ack,
                           output logic got_err, output logic [31:0] got_prod,
                           output int cycles);
        apply_stimulus(r, ia0, ix0, ia1, ix1);
        cycles   = 1;
        got_ack  = 2'b00;
        got_err  = 1'b0;
        got_prod = '0;
        while (ack == 2'b00 && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            if (scramble && cycles == 2) begin
                a0 = 16'sd100;
                x0 = x0 + 16'sd1;
                a1 = ~a1;
                x1 = x1 - 16'sd3;
            end
        end
        if (ack == 2'b00) begin
            tests_run++;
            failures++;
            $display("[TB] FAIL ack_wait: got no ack expected ack within %0d cycles", BUDGET);
            req = 2'b00;
            return;
        end
        got_ack  = ack;
        got_err  = err;
        got_prod = product;
        req      = req & ~drop;
        @(negedge clk);
        check_output("ack_pulse_width", {30'd0, ack}, 32'd0);
    endtask

    initial begin : main
        logic [1:0]         g_ack;
        logic               g_err;
        logic [31:0]        g_prod;
        int                 g_cyc;
        logic [1:0]         r;
        logic signed [15:0] ra0, rx0, ra1, rx1;
        int                 lat;
        logic               win;
        int                 ack_before;
        logic [31:0]        exp_prod;
        logic [1:0]         exp_ack;
        bit                 scr;
        logic [9:0]         exp_bus [4];

        vecs[0] = '{2'b01, 16'sd3,      -16'sd5,     4, 2'b01, -32'sd15};
        vecs[1] = '{2'b10, -16'sd7,     -16'sd9,     2, 2'b10, 32'sd63};
        vecs[2] = '{2'b01, -16'sd32768, -16'sd32768, 1, 2'b01, 32'sd1073741824};
        vecs[3] = '{2'b10, 16'sd32767,  -16'sd32768, 7, 2'b10, -32'sd1073709056};
        vecs[4] = '{2'b01, 16'sd0,      16'sd1234,   3, 2'b01, 32'sd0};
        vecs[5] = '{2'b10, 16'sd255,    -16'sd256,   5, 2'b10, -32'sd65280};
        exp_bus = '{10'h200, 10'h1FF, 10'h203, 10'h1FB};

        rst = 1'b1;
        apply_stimulus(2'b00, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        repeat (3) @(negedge clk);
        check_output("reset_strobes", {18'd0, ack, err, mul_get_a, mul_get_x, mul_begin, mul_data}, 32'd0);
        check_output("reset_product", product, 32'd0);
        rst = 1'b0;
        ref_last = 1'b1;
        @(negedge clk);

        // Directed single-requester table; latency is 7 + wait cycles.
        for (int i = 0; i < 6; i++) begin
            mdl_lat = vecs[i].lat;
            mdl_stale = 0;
            mdl_never = 0;
            bus_log.delete();
            if (vecs[i].req == 2'b01)
                run_job(2'b01, vecs[i].a, vecs[i].x, 16'sd0, 16'sd0, 2'b11, 0, g_ack, g_err, g_prod, g_cyc);
            else
                run_job(2'b10, 16'sd0, 16'sd0, vecs[i].a, vecs[i].x, 2'b11, 0, g_ack, g_err, g_prod, g_cyc);
            check_output("table_ack", {30'd0, g_ack}, {30'd0, vecs[i].exp_ack});
            check_output("table_err", {31'd0, g_err}, 32'd0);
            check_output("table_product", g_prod, vecs[i].exp_prod);
            check_output("table_latency", g_cyc, 7 + vecs[i].lat);
            ref_last = vecs[i].exp_ack[1];
            if (i == 0) begin
                check_output("bus_beats", bus_log.size(), 32'd4);
                for (int k = 0; k < 4 && k < bus_log.size(); k++)
                    check_output("bus_order", {22'd0, bus_log[k]}, {22'd0, exp_bus[k]});
            end
        end

        // Simultaneous requests: requester 0 first, then requester 1.
        mdl_lat = 3;
        run_job(2'b11, 16'sd2, 16'sd7, -16'sd4, 16'sd6, 2'b01, 0, g_ack, g_err, g_prod, g_cyc);
        check_output("tie_first_ack", {30'd0, g_ack}, 32'd1);
        check_output("tie_first_product", g_prod, 32'sd14);
        run_job(2'b10, 16'sd2, 16'sd7, -16'sd4, 16'sd6, 2'b11, 0, g_ack, g_err, g_prod, g_cyc);
        check_output("tie_second_ack", {30'd0, g_ack}, 32'd2);
        check_output("tie_second_product", g_prod, -32'sd24);
        ref_last = 1'b1;

        // Ready still high from the last job at START, drops, then rises.
        mdl_stale = 1;
        mdl_stale_hold = 3;
        mdl_lat = 6;
        run_job(2'b01, 16'sd21, 16'sd2, 16'sd0, 16'sd0, 2'b11, 0, g_ack, g_err, g_prod, g_cyc);
        check_output("stale_latency", g_cyc, 13);
        check_output("stale_product", g_prod, 32'sd42);
        check_output("stale_err", {31'd0, g_err}, 32'd0);
        ref_last = 1'b0;

        // Ready never rises: WAIT_RDY lasts TIMEOUT cycles, then error ack.
        mdl_stale = 0;
        mdl_never = 1;
        run_job(2'b10, 16'sd0, 16'sd0, 16'sd9, 16'sd9, 2'b11, 0, g_ack, g_err, g_prod, g_cyc);
        check_output("timeout_ack", {30'd0, g_ack}, 32'd2);
        check_output("timeout_err", {31'd0, g_err}, 32'd1);
        check_output("timeout_product_held", g_prod, 32'sd42);
        check_output("timeout_latency", g_cyc, 7 + TIMEOUT);
        ref_last = 1'b1;

        // Operands altered right after grant must not affect the result.
        mdl_never = 0;
        mdl_lat = 2;
        run_job(2'b01, 16'sd7, 16'sd9, 16'sd0, 16'sd0, 2'b11, 1, g_ack, g_err, g_prod, g_cyc);
        check_output("latched_operand_product", g_prod, 32'sd63);
        ref_last = 1'b0;

        // Reset during WAIT_RDY abandons the job without an ack.
        mdl_lat = 30;
        apply_stimulus(2'b01, 16'sd11, 16'sd13, 16'sd0, 16'sd0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        req = 2'b00;
        #1;
        check_output("midjob_reset_strobes", {18'd0, ack, err, mul_get_a, mul_get_x, mul_begin, mul_data}, 32'd0);
        check_output("midjob_reset_product", product, 32'd0);
        ack_before = ack_pulses;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_last = 1'b1;
        repeat (40) @(negedge clk);
        check_output("no_ack_after_reset", ack_pulses - ack_before, 32'd0);
        mdl_lat = 2;
        run_job(2'b11, -16'sd3, -16'sd3, 16'sd5, 16'sd5, 2'b01, 0, g_ack, g_err, g_prod, g_cyc);
        check_output("post_reset_first_ack", {30'd0, g_ack}, 32'd1);
        check_output("post_reset_first_product", g_prod, 32'sd9);
        run_job(2'b10, -16'sd3, -16'sd3, 16'sd5, 16'sd5, 2'b11, 0, g_ack, g_err, g_prod, g_cyc);
        check_output("post_reset_second_ack", {30'd0, g_ack}, 32'd2);
        check_output("post_reset_second_product", g_prod, 32'sd25);
        ref_last = 1'b1;

        // Randomized jobs against the round-robin / arithmetic reference.
        for (int j = 0; j < 30; j++) begin
            r   = 2'($urandom_range(1, 3));
            ra0 = 16'($urandom);
            rx0 = 16'($urandom);
            ra1 = 16'($urandom);
            rx1 = 16'($urandom);
            lat = $urandom_range(1, 12);
            scr = 1'($urandom_range(0, 1));
            mdl_lat = lat;
            mdl_stale = (lat >= 2) && ($urandom_range(0, 1) == 1);
            if (mdl_stale) mdl_stale_hold = $urandom_range(1, lat - 1);
            win      = (r == 2'b11) ? ~ref_last : (r == 2'b10);
            exp_ack  = win ? 2'b10 : 2'b01;
            exp_prod = win ? 32'(int'(ra1) * int'(rx1)) : 32'(int'(ra0) * int'(rx0));
            run_job(r, ra0, rx0, ra1, rx1, 2'b11, scr, g_ack, g_err, g_prod, g_cyc);
            check_output("rand_ack", {30'd0, g_ack}, {30'd0, exp_ack});
            check_output("rand_err", {31'd0, g_err}, 32'd0);
            check_output("rand_product", g_prod, exp_prod);
            check_output("rand_latency", g_cyc, 7 + lat);
            ref_last = win;
        end

        check_output("strobe_onehot", onehot_violations, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
